// File: rtl/stream_compare_pkg.sv
// Shared helpers for the multi-channel stream comparator: FIFO address sizing
// and saturating counter increment.
package stream_compare_pkg;

    // Widest counter the saturating helper supports.
    localparam int unsigned SAT_MAX_W = 64;

    function automatic int unsigned depth_clog2(input int unsigned depth);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(depth)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Increments value but holds at the all-ones value of the given width.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] max_v;
        if (width >= SAT_MAX_W) begin
            max_v = '1;
        end else begin
            max_v = (64'd1 << width) - 64'd1;
        end
        if (value >= max_v) begin
            return max_v;
        end
        return value + 64'd1;
    endfunction

endpackage

// File: rtl/stream_compare_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty decode only registered
// pointers, and the head word is readable in the cycle it becomes visible.
module stream_compare_fifo
    import stream_compare_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = int'(depth_clog2(DEPTH));

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Combinational head read so a word is compared the cycle after it lands.
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/stream_compare_nch.sv
// N-channel stream comparator: per-channel alignment FIFOs, word-by-word
// compare of every channel against channel 0, saturating counters.
module stream_compare_nch
    import stream_compare_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int N_CH       = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*DATA_W-1:0]     s_axis_tdata,
    input  logic [N_CH-1:0]            s_axis_tvalid,
    output logic [N_CH-1:0]            s_axis_tready,
    input  logic                       clear,
    output logic [CNT_W-1:0]           word_count,
    output logic [(N_CH-1)*CNT_W-1:0]  err_count,
    output logic                       first_err_valid,
    output logic [CNT_W-1:0]           first_err_word,
    output logic [N_CH-2:0]            first_err_mask
);

    logic                              ready_en_q;
    logic [N_CH-1:0]                   full;
    logic [N_CH-1:0]                   empty;
    logic [N_CH-1:0]                   wr_en;
    logic [N_CH-1:0][DATA_W-1:0]       head;
    logic                              do_compare;
    logic [N_CH-2:0]                   mismatch;

    logic [CNT_W-1:0]                  word_count_q,  word_count_d;
    logic [N_CH-2:0][CNT_W-1:0]        err_count_q,   err_count_d;
    logic                              first_err_valid_q, first_err_valid_d;
    logic [CNT_W-1:0]                  first_err_word_q,  first_err_word_d;
    logic [N_CH-2:0]                   first_err_mask_q,  first_err_mask_d;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        logic [SAT_MAX_W-1:0] ext;
        ext            = '0;
        ext[CNT_W-1:0] = v;
        ext            = sat_inc(ext, CNT_W);
        return ext[CNT_W-1:0];
    endfunction

    // ready_en_q keeps tready low through reset and for its release edge.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign s_axis_tready[gi] = ready_en_q & ~full[gi];
            assign wr_en[gi]         = s_axis_tvalid[gi] & s_axis_tready[gi];

            stream_compare_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (wr_en[gi]),
                .wr_data (s_axis_tdata[gi*DATA_W +: DATA_W]),
                .rd_en   (do_compare),
                .rd_data (head[gi]),
                .full    (full[gi]),
                .empty   (empty[gi])
            );
        end

        for (genvar gi = 1; gi < N_CH; gi++) begin : g_cmp
            assign mismatch[gi-1] = (head[gi] != head[0]);
        end
    endgenerate

    assign do_compare = ~|empty;

    always_comb begin
        word_count_d      = word_count_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_word_d  = first_err_word_q;
        first_err_mask_d  = first_err_mask_q;
        if (clear) begin
            // A set popped alongside clear is dropped from the statistics.
            word_count_d      = '0;
            err_count_d       = '0;
            first_err_valid_d = 1'b0;
            first_err_word_d  = '0;
            first_err_mask_d  = '0;
        end else if (do_compare) begin
            word_count_d = cnt_inc(word_count_q);
            for (int c = 0; c < N_CH - 1; c++) begin
                if (mismatch[c]) begin
                    err_count_d[c] = cnt_inc(err_count_q[c]);
                end
            end
            if ((|mismatch) && !first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_word_d  = word_count_q;
                first_err_mask_d  = mismatch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q        <= 1'b0;
            word_count_q      <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_word_q  <= '0;
            first_err_mask_q  <= '0;
        end else begin
            ready_en_q        <= 1'b1;
            word_count_q      <= word_count_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_word_q  <= first_err_word_d;
            first_err_mask_q  <= first_err_mask_d;
        end
    end

    assign word_count      = word_count_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_word  = first_err_word_q;
    assign first_err_mask  = first_err_mask_q;

endmodule

// File: tb/tb_stream_compare_nch.sv
// Directed bench for stream_compare_nch using three instances: default
// two-channel, three-channel corruption, and a small two-channel one.
module tb_stream_compare_nch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Instance A: defaults (DATA_W=32, N_CH=2, FIFO_DEPTH=16, CNT_W=32)
    logic        rst_a, clear_a;
    logic [63:0] tdata_a;
    logic [1:0]  tvalid_a, tready_a;
    logic [31:0] wc_a, ec_a, few_a;
    logic        fev_a;
    logic [0:0]  fem_a;

    // Instance B: three channels, 8-bit data, depth 4, 8-bit counters
    logic        rst_b, clear_b;
    logic [23:0] tdata_b;
    logic [2:0]  tvalid_b, tready_b;
    logic [7:0]  wc_b, few_b;
    logic [15:0] ec_b;
    logic        fev_b;
    logic [1:0]  fem_b;

    // Instance C: two channels, 8-bit data, depth 4, 4-bit counters
    logic        rst_c, clear_c;
    logic [15:0] tdata_c;
    logic [1:0]  tvalid_c, tready_c;
    logic [3:0]  wc_c, ec_c, few_c;
    logic        fev_c;
    logic [0:0]  fem_c;

    stream_compare_nch dut_a (
        .clk(clk), .rst(rst_a), .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a),
        .s_axis_tready(tready_a), .clear(clear_a), .word_count(wc_a), .err_count(ec_a),
        .first_err_valid(fev_a), .first_err_word(few_a), .first_err_mask(fem_a)
    );

    stream_compare_nch #(.DATA_W(8), .N_CH(3), .FIFO_DEPTH(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b),
        .s_axis_tready(tready_b), .clear(clear_b), .word_count(wc_b), .err_count(ec_b),
        .first_err_valid(fev_b), .first_err_word(few_b), .first_err_mask(fem_b)
    );

    stream_compare_nch #(.DATA_W(8), .N_CH(2), .FIFO_DEPTH(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst_c), .s_axis_tdata(tdata_c), .s_axis_tvalid(tvalid_c),
        .s_axis_tready(tready_c), .clear(clear_c), .word_count(wc_c), .err_count(ec_c),
        .first_err_valid(fev_c), .first_err_word(few_c), .first_err_mask(fem_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
        tvalid_a = '0; tvalid_b = '0; tvalid_c = '0;
        tdata_a = '0; tdata_b = '0; tdata_c = '0;
        step(); step();
        vectors++;
        if (tready_a !== 2'b00) begin
            miscompares++; $display("FAIL reset_tready_low got %b want 00", tready_a);
        end
        vectors++;
        if (tready_b !== 3'b000) begin
            miscompares++; $display("FAIL reset_tready_low_b got %b want 000", tready_b);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        step();
        vectors++;
        if (tready_a !== 2'b11) begin
            miscompares++; $display("FAIL reset_tready_a got %b want 11", tready_a);
        end
        vectors++;
        if (tready_b !== 3'b111) begin
            miscompares++; $display("FAIL reset_tready_b got %b want 111", tready_b);
        end
        vectors++;
        if (tready_c !== 2'b11) begin
            miscompares++; $display("FAIL reset_tready_c got %b want 11", tready_c);
        end
        vectors++;
        if ({wc_a, ec_a, fev_a, few_a, fem_a} !== 98'd0) begin
            miscompares++;
            $display("FAIL reset_outputs wc=%0d ec=%0d fev=%b few=%0d fem=%b want all 0",
                     wc_a, ec_a, fev_a, few_a, fem_a);
        end
        $display("test_reset done");
    endtask

    task automatic test_aligned();
        logic [31:0] d;
        int not_ready;
        not_ready = 0;
        for (int i = 0; i < 100; i++) begin
            d = 32'hC0DE_0000 + 32'(i);
            tdata_a  = {d, d};
            tvalid_a = 2'b11;
            if (tready_a !== 2'b11) not_ready++;
            step();
        end
        tvalid_a = 2'b00;
        step(); step();
        vectors++;
        if (not_ready != 0) begin
            miscompares++; $display("FAIL aligned_tready low in %0d cycles want 0", not_ready);
        end
        vectors++;
        if (wc_a !== 32'd100) begin
            miscompares++; $display("FAIL aligned_word_count got %0d want 100", wc_a);
        end
        vectors++;
        if (ec_a !== 32'd0 || fev_a !== 1'b0) begin
            miscompares++; $display("FAIL aligned_errors ec=%0d fev=%b want 0 0", ec_a, fev_a);
        end
        $display("test_aligned: 100 sets, word_count=%0d", wc_a);
    endtask

    task automatic test_single_corruption();
        logic [7:0] base, d2;
        for (int i = 0; i < 20; i++) begin
            base     = 8'(i * 3 + 1);
            d2       = (i == 7) ? (base ^ 8'h55) : base;
            tdata_b  = {d2, base, base};
            tvalid_b = 3'b111;
            step();
        end
        tvalid_b = 3'b000;
        step(); step();
        vectors++;
        if (wc_b !== 8'd20) begin
            miscompares++; $display("FAIL corrupt_word_count got %0d want 20", wc_b);
        end
        vectors++;
        if (ec_b !== {8'd1, 8'd0}) begin
            miscompares++; $display("FAIL corrupt_err_count got %h want 0100", ec_b);
        end
        vectors++;
        if (fev_b !== 1'b1 || few_b !== 8'd7) begin
            miscompares++; $display("FAIL corrupt_first_err fev=%b word=%0d want 1 7", fev_b, few_b);
        end
        vectors++;
        if (fem_b !== 2'b10) begin
            miscompares++; $display("FAIL corrupt_first_mask got %b want 10", fem_b);
        end
        $display("test_single_corruption: first_err_word=%0d mask=%b", few_b, fem_b);
    endtask

    task automatic test_skew();
        int acc0, acc1;
        logic r0, r1;
        bit done;
        acc0 = 0; acc1 = 0;
        for (int k = 0; k < 8; k++) begin
            tdata_c  = {8'(8'h40 + acc1), 8'h00};
            tvalid_c = {(acc1 < 6), 1'b0};
            r1 = tvalid_c[1] & tready_c[1];
            step();
            if (r1) acc1++;
        end
        vectors++;
        if (acc1 != 4) begin
            miscompares++; $display("FAIL skew_accepted got %0d want 4", acc1);
        end
        vectors++;
        if (tready_c !== 2'b01) begin
            miscompares++; $display("FAIL skew_backpressure got %b want 01", tready_c);
        end
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tdata_c  = {8'(8'h40 + acc1), 8'(8'h40 + acc0)};
            tvalid_c = {(acc1 < 6), (acc0 < 6)};
            r0 = tvalid_c[0] & tready_c[0];
            r1 = tvalid_c[1] & tready_c[1];
            step();
            if (r0) acc0++;
            if (r1) acc1++;
            done = (acc0 >= 6) && (acc1 >= 6);
        end
        tvalid_c = 2'b00;
        vectors++;
        if (!done) begin
            miscompares++; $display("FAIL skew_timeout acc0=%0d acc1=%0d want 6 6", acc0, acc1);
        end
        step(); step();
        vectors++;
        if (wc_c !== 4'd6) begin
            miscompares++; $display("FAIL skew_word_count got %0d want 6", wc_c);
        end
        vectors++;
        if (ec_c !== 4'd0 || fev_c !== 1'b0) begin
            miscompares++; $display("FAIL skew_errors ec=%0d fev=%b want 0 0", ec_c, fev_c);
        end
        $display("test_skew: word_count=%0d err_count=%0d", wc_c, ec_c);
    endtask

    task automatic test_saturation();
        clear_c = 1'b1;
        step();
        clear_c = 1'b0;
        vectors++;
        if (wc_c !== 4'd0) begin
            miscompares++; $display("FAIL sat_clear got %0d want 0", wc_c);
        end
        for (int i = 0; i < 20; i++) begin
            tdata_c  = {~8'(i), 8'(i)};
            tvalid_c = 2'b11;
            step();
        end
        tvalid_c = 2'b00;
        step(); step();
        vectors++;
        if (wc_c !== 4'hF) begin
            miscompares++; $display("FAIL sat_word_count got %0d want 15", wc_c);
        end
        vectors++;
        if (ec_c !== 4'hF) begin
            miscompares++; $display("FAIL sat_err_count got %0d want 15", ec_c);
        end
        vectors++;
        if (fev_c !== 1'b1 || few_c !== 4'd0 || fem_c !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_first_err fev=%b word=%0d mask=%b want 1 0 1", fev_c, few_c, fem_c);
        end
        $display("test_saturation: word_count=%0d err_count=%0d", wc_c, ec_c);
    endtask

    task automatic test_clear_coincident();
        logic [31:0] d;
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        vectors++;
        if (wc_a !== 32'd0) begin
            miscompares++; $display("FAIL clear_idle got %0d want 0", wc_a);
        end
        for (int k = 0; k < 4; k++) begin
            d        = 32'h1000 + 32'(k);
            tdata_a  = {((k == 3) ? (d ^ 32'hFF) : d), d};
            tvalid_a = 2'b11;
            step();
        end
        vectors++;
        if (wc_a !== 32'd3 || fev_a !== 1'b0) begin
            miscompares++; $display("FAIL clear_pre got wc=%0d fev=%b want 3 0", wc_a, fev_a);
        end
        // Set 3 (the mismatch) is compared in this cycle together with clear.
        clear_a  = 1'b1;
        tvalid_a = 2'b00;
        step();
        clear_a = 1'b0;
        vectors++;
        if (wc_a !== 32'd0 || fev_a !== 1'b0 || ec_a !== 32'd0) begin
            miscompares++;
            $display("FAIL clear_coincident wc=%0d fev=%b ec=%0d want 0 0 0", wc_a, fev_a, ec_a);
        end
        tdata_a  = {32'h2, 32'h1};
        tvalid_a = 2'b11;
        step();
        tvalid_a = 2'b00;
        step(); step();
        vectors++;
        if (fev_a !== 1'b1 || few_a !== 32'd0) begin
            miscompares++; $display("FAIL clear_next_capture fev=%b word=%0d want 1 0", fev_a, few_a);
        end
        vectors++;
        if (wc_a !== 32'd1 || ec_a !== 32'd1) begin
            miscompares++; $display("FAIL clear_next_counts wc=%0d ec=%0d want 1 1", wc_a, ec_a);
        end
        $display("test_clear_coincident: first_err_word=%0d", few_a);
    endtask

    task automatic test_reset_midstream();
        tvalid_a = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tdata_a = {32'h0, 32'h11 + 32'(k)};
            step();
        end
        tvalid_a = 2'b00;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        vectors++;
        if ({wc_a, ec_a, fev_a, few_a, fem_a} !== 98'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs wc=%0d ec=%0d fev=%b few=%0d fem=%b want all 0",
                     wc_a, ec_a, fev_a, few_a, fem_a);
        end
        vectors++;
        if (tready_a !== 2'b00) begin
            miscompares++; $display("FAIL rst_mid_tready_low got %b want 00", tready_a);
        end
        step();
        vectors++;
        if (tready_a !== 2'b11) begin
            miscompares++; $display("FAIL rst_mid_tready_high got %b want 11", tready_a);
        end
        tdata_a  = {32'hABCD, 32'hABCD};
        tvalid_a = 2'b11;
        step();
        tdata_a  = {32'h6, 32'h5};
        step();
        tvalid_a = 2'b00;
        step(); step();
        vectors++;
        if (wc_a !== 32'd2 || ec_a !== 32'd1) begin
            miscompares++; $display("FAIL rst_mid_counts wc=%0d ec=%0d want 2 1", wc_a, ec_a);
        end
        vectors++;
        if (fev_a !== 1'b1 || few_a !== 32'd1) begin
            miscompares++; $display("FAIL rst_mid_capture fev=%b word=%0d want 1 1", fev_a, few_a);
        end
        $display("test_reset_midstream: word_count=%0d first_err_word=%0d", wc_a, few_a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aligned();
        test_single_corruption();
        test_skew();
        test_saturation();
        test_clear_coincident();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_compare_nch.md
# stream_compare_nch

Parametrised multi-channel stream comparator for link and loopback test benches in the fabric. It accepts N_CH AXI-Stream inputs, aligns them through per-channel FIFOs so the streams need not arrive in the same cycle, and compares channel 0 (reference) word-by-word against every other channel. It reports saturating word and per-channel error counts and captures the first mismatch. Unlike the fixed two-input comparator, it applies real back-pressure and cannot lose words to skew between inputs.

## Interface
Parameters:
- DATA_W, 32, data width per channel
- N_CH, 2, number of input channels (≥2); channel 0 is the reference
- FIFO_DEPTH, 16, words per channel FIFO; power of two, ≥2
- CNT_W, 32, width of every counter

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- s_axis_tvalid  in  N_CH  per-channel valid
- s_axis_tready  out  N_CH  per-channel ready
- clear  in  1  synchronous clear of counters and first-error capture
- word_count  out  CNT_W  aligned word sets compared
- err_count  out  (N_CH-1)*CNT_W  mismatches of channel c vs channel 0, slice c-1
- first_err_valid  out  1  a mismatch has been captured since reset/clear
- first_err_word  out  CNT_W  0-based word index of the first mismatching set
- first_err_mask  out  N_CH-1  channels mismatching in that set (bit c-1 = channel c)

## Operation
- Each channel owns one FIFO. s_axis_tready[c] = !full[c], driven from registered state only (no combinational path from any input).
- A word is written when tvalid[c] && tready[c].
- Compare fires in any cycle where all FIFOs are non-empty. It pops one word from every FIFO simultaneously; at most one set is compared per cycle.
- On compare:
  - word_count increments.
  - For each c ≥ 1 where data[c] != data[0], err_count[c-1] increments.
  - If any channel mismatches and first_err_valid=0: set first_err_valid=1, first_err_word = pre-increment word_count, first_err_mask = mismatch vector.
- Saturation: every counter holds at 2^CNT_W-1. word_count saturated does not stop compares or error counting. first_err_word captures the saturated value.
- clear: zeroes all counters, first_err_valid, first_err_word and first_err_mask. FIFOs and their contents are untouched. If a compare occurs in the same cycle as clear, clear wins: that set is popped but not counted and not captured.
- Reset values: all counters 0, first_err_valid 0, first_err_word 0, first_err_mask 0, all FIFOs empty. s_axis_tready is all 1 from the first cycle after rst deasserts and 0 while rst is high.
- rst asserted mid-stream discards all FIFO contents. Words in flight are lost, not compared.

## Timing
- Write at edge E makes the word visible (non-empty) in the cycle after E.
- The compare happens in that cycle. Counters and capture update at the next edge.
- A word set whose last word is accepted in cycle t is reflected in the outputs from cycle t+2.
- Full FIFO: tready is low even if a pop occurs in the same cycle. It rises the cycle after the pop.
- Steady state with all channels valid every cycle: one compare per cycle, tready stays high, FIFOs stay at occupancy ≤1.
- Skew: a channel may lead the others by up to FIFO_DEPTH words before it is back-pressured.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.

## Structure
- Package stream_compare_pkg holds:
  - a helper function for the clog2 of FIFO_DEPTH
  - the counter-saturation increment function, parameterised by CNT_W
- Sub-module stream_compare_fifo: single-clock synchronous FIFO with DATA_W, DEPTH, wr_en, rd_en, full, empty and registered-pointer flags.
- Instantiated N_CH times in a generate loop. Compare and counter logic lives in the top.

## Test plan
- Aligned stream, N_CH=2: 100 identical words on both channels every cycle -> word_count=100, err_count=0, first_err_valid=0, tready constantly 1.
- Single corruption, N_CH=3: channel 2 word 7 differs, 20 words total -> word_count=20, err_count slices {0,1}, first_err_word=7, first_err_mask=2'b10.
- Skew, FIFO_DEPTH=4: channel 1 sends 6 words while channel 0 is idle -> tready[1] drops after 4 accepted words. Channel 0 then sends 6 matching words -> word_count=6, err_count=0.
- Saturation, CNT_W=4: 20 mismatching sets -> word_count=15, err_count=15, first_err_word=0.
- clear coincident with a mismatching compare at word 3 -> next cycle word_count=0, first_err_valid=0. The following mismatch at the next set captures first_err_word=0.
- rst pulse with 3 words queued on channel 0 only -> all outputs 0, all FIFOs empty. The next aligned set compares as word 0.
